// File: rtl/wb_sram_slave.sv
// Wishbone slave backed by a single-port 32-bit SRAM.
// Classic cycles with programmable wait states and one-beat-per-cycle incrementing bursts.
module wb_sram_slave #(
  parameter int adr_width   = 10,
  parameter int wait_states = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  localparam int          DEPTH    = 1 << adr_width;
  localparam logic [3:0]  WS       = 4'(wait_states);
  localparam logic [2:0]  CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BURST
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic [adr_width-1:0]   burst_adr_q;
  logic [31:0]            mem [DEPTH];

  logic                   req;
  logic [adr_width-1:0]   idx;
  logic                   beat;
  logic                   incr;
  logic                   prefetch;
  logic [adr_width-1:0]   prefetch_adr;
  logic                   unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign idx        = wb_adr_i[adr_width+1:2];
  assign unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; dropping cyc anywhere past IDLE abandons the access.
  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = (WS == 4'd0) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        if (!wb_cyc_i)          state_d = ST_IDLE;
        else if (cnt_q == 4'd0) state_d = ST_ACK;
      end
      ST_ACK, ST_BURST: begin
        if (!wb_cyc_i) state_d = ST_IDLE;
        else if (beat) state_d = incr ? ST_BURST : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath-control decode.
  always_comb begin
    wb_ack_o     = ((state_q == ST_ACK) || (state_q == ST_BURST)) & wb_cyc_i & wb_stb_i;
    beat         = wb_ack_o;
    incr         = beat && (wb_cti_i == CTI_INCR);
    prefetch     = 1'b0;
    prefetch_adr = burst_adr_q;
    if (state_q == ST_IDLE && req && WS == 4'd0) begin
      prefetch     = 1'b1;
      prefetch_adr = idx;
    end else if (state_q == ST_WAIT && wb_cyc_i && cnt_q == 4'd0) begin
      prefetch = 1'b1;
    end else if (incr) begin
      // The next burst word is fetched while the current beat completes; wraps at the top.
      prefetch     = 1'b1;
      prefetch_adr = burst_adr_q + adr_width'(1);
    end
  end

  // Wait counter, burst address and registered read data.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt_q       <= 4'd0;
      burst_adr_q <= '0;
      wb_dat_o    <= 32'd0;
    end else begin
      if (state_q == ST_IDLE && req) begin
        burst_adr_q <= idx;
        cnt_q       <= WS;
      end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (incr)     burst_adr_q <= burst_adr_q + adr_width'(1);
      if (prefetch) wb_dat_o    <= mem[prefetch_adr];
    end
  end

  // Byte-lane writes land on the beat edge at the current burst address.
  // NOTE: the memory array has no reset; clearing it would prevent RAM inference.
  always_ff @(posedge sys_clk) begin
    if (beat && wb_we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_i[i]) mem[burst_adr_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

endmodule
